// File: rtl/cpu_run_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_run_sequencer
//
// Host-side initiator for the CPU top level's req/done run handshake.
// One run does the following:
//   1. Preloads LOAD_N operand words into data memory through the shared memory
//      port. The words arrive on a valid/ready stream.
//   2. Releases the CPU from reset and pulses cpu_req for one cycle.
//   3. Waits for cpu_done. If it does not arrive within TIMEOUT cycles, the
//      run aborts and the sticky timeout flag is set.
//   4. Streams RES_N result words out of data memory over a valid/ready
//      interface.
//   5. Pulses finished for one cycle.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   start                  begin a run (sampled only while idle)
//   busy                   high whenever a run is in progress
//   ld_valid/ld_data       preload word stream in
//   ld_ready               this block accepts ld_data this cycle
//   cpu_reset, cpu_req     reset and run request to the CPU top level
//   cpu_done               CPU finished (level, only looked at while running)
//   mem_sel                1 = this block owns the data-memory port, 0 = CPU
//   mem_addr/mem_wr_en/mem_wr_data/mem_rd_data
//                          data-memory port (the read is combinational)
//   res_valid/res_data/res_last/res_ready
//                          result word stream out
//   timeout                sticky, the last run aborted waiting for cpu_done
//   finished               one-cycle pulse at the end of every run
//   run_cycles             (CYCLE_COUNT_EN only) RUN length of the last run
//
// Optional feature: define CYCLE_COUNT_EN to add the run_cycles output.
// -----------------------------------------------------------------------------
module cpu_run_sequencer #(
    parameter int LOAD_BASE = 0,
    parameter int LOAD_N    = 2,
    parameter int RES_BASE  = 4,
    parameter int RES_N     = 2,
    parameter int TIMEOUT   = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    output logic        cpu_reset,
    output logic        cpu_req,
    input  logic        cpu_done,
    output logic        mem_sel,
    output logic [7:0]  mem_addr,
    output logic        mem_wr_en,
    output logic [7:0]  mem_wr_data,
    input  logic [7:0]  mem_rd_data,
    output logic        res_valid,
    output logic [7:0]  res_data,
    output logic        res_last,
    input  logic        res_ready,
    output logic        timeout,
    output logic        finished
`ifdef CYCLE_COUNT_EN
    ,
    output logic [15:0] run_cycles
`endif
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [15:0]   LOAD_LAST = 16'(LOAD_N - 1);
    localparam logic [15:0]   RES_LAST  = 16'(RES_N - 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        KICK,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // These control outputs depend only on the state (and on the drain index
    // for res_last). They are registered from the next-state value, so each
    // one comes straight from a flop.
    typedef struct packed {
        logic busy;
        logic ld_ready;
        logic cpu_reset;
        logic cpu_req;
        logic mem_sel;
        logic res_valid;
        logic res_last;
        logic finished;
    } outs_t;

    state_t        state, state_nxt;
    logic [15:0]   idx, idx_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic          timeout_nxt;
    outs_t         outs;

    function automatic outs_t decode(state_t s, logic [15:0] i);
        outs_t o;
        o           = '0;
        o.busy      = (s != IDLE);
        o.cpu_reset = 1'b1;
        o.mem_sel   = 1'b1;
        case (s)
            LOAD:  o.ld_ready = 1'b1;
            KICK:  begin
                o.cpu_reset = 1'b0;
                o.mem_sel   = 1'b0;
                o.cpu_req   = 1'b1;
            end
            RUN:   begin
                o.cpu_reset = 1'b0;
                o.mem_sel   = 1'b0;
            end
            DRAIN: begin
                o.res_valid = 1'b1;
                o.res_last  = (i == RES_LAST);
            end
            DONE:  o.finished = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    assign cnt_inc = cnt + 1'b1;

    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves a value
        // unassigned and no latch is inferred.
        state_nxt   = state;
        idx_nxt     = idx;
        cnt_nxt     = cnt;
        timeout_nxt = timeout;
        case (state)
            IDLE: if (start) begin
                timeout_nxt = 1'b0;
                idx_nxt     = '0;
                state_nxt   = (LOAD_N == 0) ? KICK : LOAD;
            end
            LOAD: if (ld_valid) begin
                idx_nxt = idx + 1'b1;
                if (idx == LOAD_LAST) state_nxt = KICK;
            end
            KICK: begin
                cnt_nxt   = '0;
                state_nxt = RUN;
            end
            RUN: begin
                cnt_nxt = cnt_inc;
                // If done and the limit land on the same cycle, done wins.
                if (cpu_done) begin
                    idx_nxt   = '0;
                    state_nxt = (RES_N == 0) ? DONE : DRAIN;
                end else if (cnt_inc == CNT_LIMIT) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = DONE;
                end
            end
            DRAIN: if (res_ready) begin
                idx_nxt = idx + 1'b1;
                if (idx == RES_LAST) state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only. All flops
        // then update together at the edge, whatever order they are written in.
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            timeout <= 1'b0;
            outs    <= decode(IDLE, '0);
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            cnt     <= cnt_nxt;
            timeout <= timeout_nxt;
            outs    <= decode(state_nxt, idx_nxt);
        end
    end

    assign busy      = outs.busy;
    assign ld_ready  = outs.ld_ready;
    assign cpu_reset = outs.cpu_reset;
    assign cpu_req   = outs.cpu_req;
    assign mem_sel   = outs.mem_sel;
    assign res_valid = outs.res_valid;
    assign res_last  = outs.res_last;
    assign finished  = outs.finished;

    // Writes happen only while ld_ready is high, and that is only in LOAD.
    assign mem_wr_en   = outs.ld_ready & ld_valid;
    assign mem_wr_data = ld_data;

    // The 8-bit addition wraps modulo 256 on purpose.
    assign mem_addr = outs.res_valid ? (8'(RES_BASE)  + idx[7:0])
                                     : (8'(LOAD_BASE) + idx[7:0]);

    // The read is combinational. The index only advances on a handshake, so
    // res_data holds steady while the consumer stalls.
    assign res_data = mem_rd_data;

`ifdef CYCLE_COUNT_EN
    logic [31:0] run_len;
    assign run_len = 32'(cnt_inc);

    always_ff @(posedge clk) begin
        if (reset) begin
            run_cycles <= '0;
        end else if (state == RUN && state_nxt != RUN) begin
            run_cycles <= (run_len > 32'h0000_FFFF) ? 16'hFFFF : run_len[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for cpu_run_sequencer. Three instances run side by side:
//   0: default parameters
//   1: TIMEOUT=8, LOAD_BASE=255 (preload addresses wrap)
//   2: LOAD_N=0, RES_N=0
// -----------------------------------------------------------------------------
module tb_cpu_run_sequencer;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset;
    logic [NI-1:0]         start, ld_valid, cpu_done, res_ready;
    logic [NI-1:0][7:0]    ld_data, mem_rd_data;
    logic [NI-1:0]         busy, ld_ready, cpu_reset, cpu_req, mem_sel, mem_wr_en;
    logic [NI-1:0]         res_valid, res_last, timeout, finished;
    logic [NI-1:0][7:0]    mem_addr, mem_wr_data, res_data;
`ifdef CYCLE_COUNT_EN
    logic [NI-1:0][15:0]   run_cycles;
`endif
    logic [7:0]            img [NI][256];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        cpu_run_sequencer #(
            .LOAD_BASE (g == 1 ? 255 : 0),
            .LOAD_N    (g == 2 ? 0 : 2),
            .RES_BASE  (4),
            .RES_N     (g == 2 ? 0 : 2),
            .TIMEOUT   (g == 1 ? 8 : 4096)
        ) dut (
            .clk         (clk),
            .reset       (reset),
            .start       (start[g]),
            .busy        (busy[g]),
            .ld_valid    (ld_valid[g]),
            .ld_data     (ld_data[g]),
            .ld_ready    (ld_ready[g]),
            .cpu_reset   (cpu_reset[g]),
            .cpu_req     (cpu_req[g]),
            .cpu_done    (cpu_done[g]),
            .mem_sel     (mem_sel[g]),
            .mem_addr    (mem_addr[g]),
            .mem_wr_en   (mem_wr_en[g]),
            .mem_wr_data (mem_wr_data[g]),
            .mem_rd_data (mem_rd_data[g]),
            .res_valid   (res_valid[g]),
            .res_data    (res_data[g]),
            .res_last    (res_last[g]),
            .res_ready   (res_ready[g]),
            .timeout     (timeout[g]),
            .finished    (finished[g])
`ifdef CYCLE_COUNT_EN
            ,
            .run_cycles  (run_cycles[g])
`endif
        );
        assign mem_rd_data[g] = img[g][mem_addr[g]];
    end

    // Flag order: {busy, ld_ready, cpu_reset, cpu_req, mem_sel, mem_wr_en,
    //              res_valid, res_last, finished}
    localparam logic [8:0] F_IDLE = 9'b0_0_1_0_1_0_0_0_0;
    localparam logic [8:0] F_LDW  = 9'b1_1_1_0_1_1_0_0_0;
    localparam logic [8:0] F_LDS  = 9'b1_1_1_0_1_0_0_0_0;
    localparam logic [8:0] F_KICK = 9'b1_0_0_1_0_0_0_0_0;
    localparam logic [8:0] F_RUN  = 9'b1_0_0_0_0_0_0_0_0;
    localparam logic [8:0] F_DRN  = 9'b1_0_1_0_1_0_1_0_0;
    localparam logic [8:0] F_DRL  = 9'b1_0_1_0_1_0_1_1_0;
    localparam logic [8:0] F_DONE = 9'b1_0_1_0_1_0_0_0_1;

    typedef struct {
        int         rep;
        logic       rst, st, lv;
        logic [7:0] ld;
        logic       dn, rdy;
        logic [8:0] fl;
        logic [7:0] ad, dt;
        logic       tmo;
    } vec_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   vec_no  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input int rep, input bit rst, input bit st, input bit lv,
                       input logic [7:0] ld, input bit dn, input bit rdy,
                       input logic [8:0] fl, input logic [7:0] ad,
                       input logic [7:0] dt, input bit tmo);
        vec_t v;
        v.rep = rep; v.rst = rst; v.st = st; v.lv = lv; v.ld = ld; v.dn = dn;
        v.rdy = rdy; v.fl = fl; v.ad = ad; v.dt = dt; v.tmo = tmo;
        tbl.push_back(v);
    endtask

    // Apply every queued vector to instance g, then empty the table.
    task automatic run_tbl(input int g);
        foreach (tbl[k]) begin
            vec_t v;
            v = tbl[k];
            for (int r = 0; r < v.rep; r++) begin
                @(negedge clk);
                reset        = v.rst;
                start[g]     = v.st;
                ld_valid[g]  = v.lv;
                ld_data[g]   = v.ld;
                cpu_done[g]  = v.dn;
                res_ready[g] = v.rdy;
                #1;
                check($sformatf("g%0d v%0d flags", g, vec_no),
                      32'({busy[g], ld_ready[g], cpu_reset[g], cpu_req[g], mem_sel[g],
                           mem_wr_en[g], res_valid[g], res_last[g], finished[g]}),
                      32'(v.fl));
                if (v.fl[3]) begin
                    check($sformatf("g%0d v%0d wr_addr", g, vec_no), 32'(mem_addr[g]), 32'(v.ad));
                    check($sformatf("g%0d v%0d wr_data", g, vec_no), 32'(mem_wr_data[g]), 32'(v.dt));
                end
                if (v.fl[2]) begin
                    check($sformatf("g%0d v%0d rd_addr", g, vec_no), 32'(mem_addr[g]), 32'(v.ad));
                    check($sformatf("g%0d v%0d res_data", g, vec_no), 32'(res_data[g]), 32'(v.dt));
                end
                check($sformatf("g%0d v%0d timeout", g, vec_no), 32'(timeout[g]), 32'(v.tmo));
            end
            vec_no++;
        end
        tbl.delete();
        @(negedge clk);
        start[g] = 1'b0; ld_valid[g] = 1'b0; cpu_done[g] = 1'b0; res_ready[g] = 1'b0;
    endtask

    // One randomized run on instance 0, judged at transaction level: two writes
    // to addresses 0 and 1, a CPU window of exactly d cycles, two results read
    // from addresses 4 and 5 (the second one flagged last), and one finished
    // pulse.
    task automatic random_run(input int k);
        logic [7:0] w [2];
        logic [7:0] r [2];
        int d, ptr, nres, nfin, nrun, since_kick;
        bit kicked;
        w[0] = 8'($urandom); w[1] = 8'($urandom);
        r[0] = 8'($urandom); r[1] = 8'($urandom);
        img[0][4] = r[0]; img[0][5] = r[1];
        d = $urandom_range(1, 20);
        ptr = 0; nres = 0; nfin = 0; nrun = 0; since_kick = 0; kicked = 1'b0;
        for (int c = 0; c < 300 && nfin == 0; c++) begin
            @(negedge clk);
            start[0]     = (c == 0) || ($urandom_range(0, 3) == 0);
            ld_valid[0]  = (ptr < 2) && ($urandom_range(0, 2) != 0);
            ld_data[0]   = (ld_valid[0] && ptr < 2) ? w[ptr] : 8'($urandom);
            if (kicked) since_kick++;
            cpu_done[0]  = kicked && (since_kick >= d);
            res_ready[0] = ($urandom_range(0, 2) != 0);
            #1;
            if (c > 0) check($sformatf("rnd%0d wr_en", k), 32'(mem_wr_en[0]),
                             32'(ld_valid[0] & ld_ready[0]));
            if (mem_wr_en[0]) begin
                if (ptr < 2) begin
                    check($sformatf("rnd%0d wr_addr", k), 32'(mem_addr[0]), 32'(ptr));
                    check($sformatf("rnd%0d wr_data", k), 32'(mem_wr_data[0]), 32'(w[ptr]));
                end else begin
                    check($sformatf("rnd%0d extra write", k), 32'd1, 32'd0);
                end
                ptr++;
            end
            if (cpu_req[0]) kicked = 1'b1;
            if (!cpu_reset[0] && !cpu_req[0]) nrun++;
            if (res_valid[0]) begin
                if (nres < 2) begin
                    check($sformatf("rnd%0d res_data", k), 32'(res_data[0]), 32'(r[nres]));
                    check($sformatf("rnd%0d res_last", k), 32'(res_last[0]), 32'(nres == 1));
                end
                if (res_ready[0]) nres++;
            end
            if (finished[0]) nfin++;
        end
        @(negedge clk);
        start[0] = 1'b0; ld_valid[0] = 1'b0; cpu_done[0] = 1'b0; res_ready[0] = 1'b0;
        check($sformatf("rnd%0d finished", k), 32'(nfin), 32'd1);
        check($sformatf("rnd%0d writes", k), 32'(ptr), 32'd2);
        check($sformatf("rnd%0d results", k), 32'(nres), 32'd2);
        check($sformatf("rnd%0d run_len", k), 32'(nrun), 32'(d));
        check($sformatf("rnd%0d timeout", k), 32'(timeout[0]), 32'd0);
        check($sformatf("rnd%0d idle", k), 32'(busy[0]), 32'd0);
`ifdef CYCLE_COUNT_EN
        check($sformatf("rnd%0d run_cycles", k), 32'(run_cycles[0]), 32'(d));
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = '0; ld_valid = '0; cpu_done = '0; res_ready = '0; ld_data = '0;
        for (int g = 0; g < NI; g++)
            for (int a = 0; a < 256; a++) img[g][a] = 8'(a) ^ 8'h3C;
        img[0][4] = 8'hAA; img[0][5] = 8'hBB;
        img[1][4] = 8'hC4; img[1][5] = 8'hC5;
        repeat (2) @(negedge clk);

        // Instance 0: reset state, then the normal run with done on RUN cycle 10.
        add(1, 0, 1, 0, 8'h00, 0, 0, F_IDLE, 8'h00, 8'h00, 0);
        add(1, 0, 0, 1, 8'h12, 0, 0, F_LDW,  8'h00, 8'h12, 0);
        add(1, 0, 0, 1, 8'h34, 0, 0, F_LDW,  8'h01, 8'h34, 0);
        add(1, 0, 0, 0, 8'h00, 0, 0, F_KICK, 8'h00, 8'h00, 0);
        add(9, 0, 0, 0, 8'h00, 0, 0, F_RUN,  8'h00, 8'h00, 0);
        add(1, 0, 0, 0, 8'h00, 1, 0, F_RUN,  8'h00, 8'h00, 0);
        add(1, 0, 0, 0, 8'h00, 0, 1, F_DRN,  8'h04, 8'hAA, 0);
        add(1, 0, 0, 0, 8'h00, 0, 1, F_DRL,  8'h05, 8'hBB, 0);
        add(1, 0, 0, 0, 8'h00, 0, 0, F_DONE, 8'h00, 8'h00, 0);
        add(1, 0, 0, 0, 8'h00, 0, 0, F_IDLE, 8'h00, 8'h00, 0);
        run_tbl(0);
`ifdef CYCLE_COUNT_EN
        check("g0 run_cycles normal", 32'(run_cycles[0]), 32'd10);
`endif

        // Instance 0: gapped preload and stalled drain. start is held during
        // LOAD and DRAIN, cpu_done during DRAIN; both must be ignored there.
        add(1, 0, 1, 0, 8'h00, 0, 0, F_IDLE, 8'h00, 8'h00, 0);
        add(3, 0, 1, 0, 8'hEE, 0, 0, F_LDS,  8'h00, 8'h00, 0);
        add(1, 0, 0, 1, 8'h56, 0, 0, F_LDW,  8'h00, 8'h56, 0);
        add(3, 0, 0, 0, 8'hEE, 0, 0, F_LDS,  8'h00, 8'h00, 0);
        add(1, 0, 0, 1, 8'h78, 0, 0, F_LDW,  8'h01, 8'h78, 0);
        add(1, 0, 0, 0, 8'h00, 0, 0, F_KICK, 8'h00, 8'h00, 0);
        add(2, 0, 0, 0, 8'h00, 0, 0, F_RUN,  8'h00, 8'h00, 0);
        add(1, 0, 0, 0, 8'h00, 1, 0, F_RUN,  8'h00, 8'h00, 0);
        add(4, 0, 1, 0, 8'h00, 1, 0, F_DRN,  8'h04, 8'hAA, 0);
        add(1, 0, 0, 0, 8'h00, 0, 1, F_DRN,  8'h04, 8'hAA, 0);
        add(2, 0, 0, 0, 8'h00, 1, 0, F_DRL,  8'h05, 8'hBB, 0);
        add(1, 0, 0, 0, 8'h00, 0, 1, F_DRL,  8'h05, 8'hBB, 0);
        add(1, 0, 0, 0, 8'h00, 0, 0, F_DONE, 8'h00, 8'h00, 0);
        add(1, 0, 0, 0, 8'h00, 1, 0, F_IDLE, 8'h00, 8'h00, 0);
        run_tbl(0);
`ifdef CYCLE_COUNT_EN
        check("g0 run_cycles stall", 32'(run_cycles[0]), 32'd3);
`endif

        // Instance 1: preload wraps 255 -> 0, then timeout after 8 RUN cycles.
        add(1, 0, 1, 0, 8'h00, 0, 0, F_IDLE, 8'h00, 8'h00, 0);
        add(1, 0, 0, 1, 8'h01, 0, 0, F_LDW,  8'hFF, 8'h01, 0);
        add(1, 0, 0, 1, 8'h02, 0, 0, F_LDW,  8'h00, 8'h02, 0);
        add(1, 0, 0, 0, 8'h00, 0, 0, F_KICK, 8'h00, 8'h00, 0);
        add(8, 0, 0, 0, 8'h00, 0, 1, F_RUN,  8'h00, 8'h00, 0);
        add(1, 0, 0, 0, 8'h00, 0, 1, F_DONE, 8'h00, 8'h00, 1);
        add(1, 0, 1, 0, 8'h00, 0, 0, F_IDLE, 8'h00, 8'h00, 1);
        // Next start clears timeout. Done coincides with the limit, so done wins.
        add(1, 0, 0, 1, 8'h03, 0, 0, F_LDW,  8'hFF, 8'h03, 0);
        add(1, 0, 0, 1, 8'h04, 0, 0, F_LDW,  8'h00, 8'h04, 0);
        add(1, 0, 0, 0, 8'h00, 0, 0, F_KICK, 8'h00, 8'h00, 0);
        add(7, 0, 0, 0, 8'h00, 0, 0, F_RUN,  8'h00, 8'h00, 0);
        add(1, 0, 0, 0, 8'h00, 1, 0, F_RUN,  8'h00, 8'h00, 0);
        add(1, 0, 0, 0, 8'h00, 0, 1, F_DRN,  8'h04, 8'hC4, 0);
        add(1, 0, 0, 0, 8'h00, 0, 1, F_DRL,  8'h05, 8'hC5, 0);
        add(1, 0, 0, 0, 8'h00, 0, 0, F_DONE, 8'h00, 8'h00, 0);
        add(1, 0, 0, 0, 8'h00, 0, 0, F_IDLE, 8'h00, 8'h00, 0);
        run_tbl(1);
`ifdef CYCLE_COUNT_EN
        check("g1 run_cycles limit", 32'(run_cycles[1]), 32'd8);
`endif

        // Instance 1: reset on the 3rd RUN cycle returns to IDLE at once.
        add(1, 0, 1, 0, 8'h00, 0, 0, F_IDLE, 8'h00, 8'h00, 0);
        add(1, 0, 0, 1, 8'h05, 0, 0, F_LDW,  8'hFF, 8'h05, 0);
        add(1, 0, 0, 1, 8'h06, 0, 0, F_LDW,  8'h00, 8'h06, 0);
        add(1, 0, 0, 0, 8'h00, 0, 0, F_KICK, 8'h00, 8'h00, 0);
        add(2, 0, 0, 0, 8'h00, 0, 0, F_RUN,  8'h00, 8'h00, 0);
        add(1, 1, 0, 0, 8'h00, 0, 0, F_RUN,  8'h00, 8'h00, 0);
        add(2, 0, 0, 0, 8'h00, 0, 0, F_IDLE, 8'h00, 8'h00, 0);
        run_tbl(1);
`ifdef CYCLE_COUNT_EN
        check("g1 run_cycles reset", 32'(run_cycles[1]), 32'd0);
`endif

        // Instance 2: no preload, no drain.
        add(1, 0, 1, 0, 8'h00, 0, 0, F_IDLE, 8'h00, 8'h00, 0);
        add(1, 0, 0, 0, 8'h00, 0, 0, F_KICK, 8'h00, 8'h00, 0);
        add(2, 0, 0, 0, 8'h00, 0, 0, F_RUN,  8'h00, 8'h00, 0);
        add(1, 0, 0, 0, 8'h00, 1, 1, F_RUN,  8'h00, 8'h00, 0);
        add(1, 0, 0, 0, 8'h00, 0, 1, F_DONE, 8'h00, 8'h00, 0);
        add(1, 0, 0, 0, 8'h00, 0, 0, F_IDLE, 8'h00, 8'h00, 0);
        run_tbl(2);
`ifdef CYCLE_COUNT_EN
        check("g2 run_cycles", 32'(run_cycles[2]), 32'd3);
`endif

        for (int k = 0; k < 30; k++) random_run(k);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_run_sequencer.md
Name: cpu_run_sequencer

Overview:
- Host-side initiator for the CPU top level's req/done run handshake.
- Preloads operands into data memory through a shared memory port, releases the CPU from reset, and pulses req.
- Waits for done, with a timeout guard, then streams a result window out of data memory over a valid/ready interface.
- Sits between the test/host harness and the CPU top level and data memory.

Parameters:
- LOAD_BASE, 0, first data-memory address written during preload
- LOAD_N, 2, number of preload words (0 = skip preload)
- RES_BASE, 4, first data-memory address read back
- RES_N, 2, number of result words (0 = skip drain)
- TIMEOUT, 4096, max RUN cycles before abort; counter width is clog2(TIMEOUT+1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  begin a run; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- ld_valid  in  1  preload word available
- ld_data  in  8  preload word
- ld_ready  out  1  block accepts ld_data this cycle
- cpu_reset  out  1  reset to CPU top level
- cpu_req  out  1  run request to CPU
- cpu_done  in  1  CPU done, a level
- mem_sel  out  1  1 = this block owns the data-memory port; 0 = CPU owns it
- mem_addr  out  8  data-memory address
- mem_wr_en  out  1  data-memory write enable
- mem_wr_data  out  8  data-memory write data
- mem_rd_data  in  8  data-memory read data (combinational read, same cycle as mem_addr)
- res_valid  out  1  result word valid
- res_data  out  8  result word
- res_last  out  1  marks final result word
- res_ready  in  1  consumer accepts result
- timeout  out  1  sticky; last run aborted
- finished  out  1  one-cycle pulse at end of run

Behaviour:
- Reset values: state IDLE, cpu_reset=1, mem_sel=1, busy=0, cpu_req=0, mem_wr_en=0, ld_ready=0, res_valid=0, res_last=0, timeout=0, finished=0, index counter 0, timeout counter 0. Reset mid-run returns to IDLE immediately.
- States: IDLE, LOAD, KICK, RUN, DRAIN, DONE.
- IDLE: start=1 clears timeout, clears index, and moves to LOAD, or to KICK if LOAD_N=0.
- LOAD:
  - ld_ready=1.
  - On ld_valid&ld_ready: mem_wr_en=1, mem_addr=LOAD_BASE+index, mem_wr_data=ld_data, index increments.
  - After the LOAD_N-th write: go to KICK.
  - ld_valid low stalls with no write.
- KICK: exactly one cycle with cpu_reset=0, cpu_req=1, mem_sel=0. Timeout counter cleared. Go to RUN.
- RUN:
  - cpu_reset=0, cpu_req=0, mem_sel=0, mem_wr_en=0.
  - Counter increments each cycle.
  - cpu_done=1: clear index, go to DRAIN, or to DONE if RES_N=0.
  - Counter==TIMEOUT with cpu_done=0: set timeout=1, go to DONE with no drain.
  - cpu_done and counter limit in the same cycle: done wins, timeout stays 0.
- DRAIN:
  - cpu_reset=1, mem_sel=1, mem_addr=RES_BASE+index.
  - res_data=mem_rd_data, res_valid=1, res_last=1 when index==RES_N-1.
  - On res_ready: index increments. After the last handshake, go to DONE.
  - res_data must stay stable while res_valid&!res_ready.
- DONE: finished=1 for one cycle, cpu_reset=1, go to IDLE.
- cpu_reset=1 in all states except KICK and RUN; mem_sel=0 exactly when cpu_reset=0.
- Addresses are 8-bit and wrap modulo 256 (e.g. LOAD_BASE=254 with LOAD_N=3 writes 254, 255, 0).
- start while busy is ignored. cpu_done is ignored outside RUN.
- mem_wr_en is never 1 outside LOAD.

Optional Feature:
- Macro: CYCLE_COUNT_EN.
- When defined: adds output run_cycles [15:0]. It holds the number of RUN cycles of the last run, including the cycle done was seen, saturating at 16'hFFFF. It is loaded on leaving RUN, cleared by reset, and held until the next RUN exit.
- When undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Normal run, defaults: start; ld words 8'h12, 8'h34 with ld_valid held -> writes addr0=8'h12, addr1=8'h34 in 2 cycles. Then KICK: cpu_req high 1 cycle. cpu_done at 10th RUN cycle -> res 8'hAA (addr4), 8'hBB (addr5, res_last=1), then finished pulse; timeout=0; run_cycles=10 with CYCLE_COUNT_EN.
- Stalls: ld_valid gapped 3 cycles between words -> no spurious writes. res_ready low 4 cycles -> res_data held, index unchanged.
- Timeout, TIMEOUT=8, cpu_done never asserted -> after 8 RUN cycles timeout=1, no res_valid, finished pulse, cpu_reset=1. Next start clears timeout.
- Simultaneous limit: TIMEOUT=8, cpu_done rises on the cycle the counter hits 8 -> DRAIN entered, timeout=0.
- Reset mid-RUN: reset=1 on 3rd RUN cycle -> next cycle IDLE, cpu_reset=1, mem_sel=1, busy=0. start asserted during LOAD -> ignored.
- Zero sizes and wrap: LOAD_N=0, RES_N=0 -> start goes straight to KICK, done goes to DONE. LOAD_BASE=255, LOAD_N=2 -> writes addr 255 then 0.
